// File: rtl/bcd_count_ctrl_if.sv
// Command, target, counter read-back and status signals between user logic and bcd_count_ctrl.
interface bcd_count_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] target_tens;
  logic [3:0] target_ones;
  logic [3:0] cnt_tens;
  logic [3:0] cnt_ones;
  logic       cnt_en;
  logic       cnt_clr;
  logic [1:0] state;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, stop, clear, target_tens, target_ones, cnt_tens, cnt_ones,
    input  cnt_en, cnt_clr, state, busy, done, err
  );

  modport slave (
    input  start, stop, clear, target_tens, target_ones, cnt_tens, cnt_ones,
    output cnt_en, cnt_clr, state, busy, done, err
  );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Sequencer for an external 00-99 BCD counter: start/stop/clear commands,
// prescaled count-enable, and stop-on-match against a latched BCD target.
module bcd_count_ctrl #(
  parameter int unsigned PRESCALE   = 4,
  parameter int unsigned PRESCALE_W = 16
) (
  input logic             clk,
  input logic             reset,
  bcd_count_ctrl_if.slave bus
);

  localparam int unsigned DIGIT_W = 4;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
  localparam logic [DIGIT_W-1:0]    BCD_MAX       = DIGIT_W'(9);

  logic [1:0]            stateQ, stateD;
  logic [PRESCALE_W-1:0] prescaleQ, prescaleD;
  logic [DIGIT_W-1:0]    tgtTensQ, tgtTensD;
  logic [DIGIT_W-1:0]    tgtOnesQ, tgtOnesD;
  logic                  errQ, errD;
  logic                  cntEn, cntClr;
  logic                  tgtValid, match;

  assign tgtValid = (bus.target_tens <= BCD_MAX) && (bus.target_ones <= BCD_MAX);
  assign match    = ({bus.cnt_tens, bus.cnt_ones} == {tgtTensQ, tgtOnesQ});

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= IDLE;
      prescaleQ <= '0;
      tgtTensQ  <= '0;
      tgtOnesQ  <= '0;
      errQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      prescaleQ <= prescaleD;
      tgtTensQ  <= tgtTensD;
      tgtOnesQ  <= tgtOnesD;
      errQ      <= errD;
    end
  end

  // Next-state and command decode; clear beats stop beats start
  always_comb begin
    stateD    = stateQ;
    prescaleD = prescaleQ;
    tgtTensD  = tgtTensQ;
    tgtOnesD  = tgtOnesQ;
    errD      = errQ;
    cntEn     = 1'b0;
    cntClr    = 1'b0;

    case (stateQ)
      IDLE, DONE: begin
        if (bus.clear) begin
          cntClr = 1'b1;
          errD   = 1'b0;
          stateD = IDLE;
        end else if (!bus.stop && bus.start) begin
          if (tgtValid) begin
            cntClr    = 1'b1;
            tgtTensD  = bus.target_tens;
            tgtOnesD  = bus.target_ones;
            prescaleD = '0;
            errD      = 1'b0;
            stateD    = RUN;
          end else begin
            errD = 1'b1;
          end
        end
      end

      RUN: begin
        if (match) begin
          stateD = DONE;
        end else if (bus.clear) begin
          cntClr    = 1'b1;
          prescaleD = '0;
          stateD    = IDLE;
        end else if (bus.stop) begin
          stateD = PAUSE;
        end else if (prescaleQ == PRESCALE_LAST) begin
          cntEn     = 1'b1;
          prescaleD = '0;
        end else begin
          prescaleD = prescaleQ + PRESCALE_W'(1);
        end
      end

      PAUSE: begin
        // Prescaler holds so a resume finishes the interrupted interval
        if (bus.clear) begin
          cntClr    = 1'b1;
          prescaleD = '0;
          stateD    = IDLE;
        end else if (!bus.stop && bus.start) begin
          stateD = RUN;
        end
      end

      default: stateD = IDLE;
    endcase
  end

  assign bus.cnt_en  = cntEn;
  assign bus.cnt_clr = cntClr;
  assign bus.state   = stateQ;
  assign bus.busy    = (stateQ == RUN) || (stateQ == PAUSE);
  assign bus.done    = (stateQ == DONE);
  assign bus.err     = errQ;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Scoreboard bench for bcd_count_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares whenever an event appears.
module tb_bcd_count_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_count_ctrl_if bus ();
  bcd_count_ctrl_if bus1 ();

  bcd_count_ctrl #(.PRESCALE(4), .PRESCALE_W(16)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  bcd_count_ctrl #(.PRESCALE(1), .PRESCALE_W(16)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // External two-digit BCD counter models
  function automatic logic [7:0] bcdInc(input logic [7:0] v);
    logic [3:0] t, o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  logic [7:0] cnt0, cnt1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt0 <= '0;
    else if (bus.cnt_clr)  cnt0 <= '0;
    else if (bus.cnt_en)   cnt0 <= bcdInc(cnt0);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt1 <= '0;
    else if (bus1.cnt_clr) cnt1 <= '0;
    else if (bus1.cnt_en)  cnt1 <= bcdInc(cnt1);
  end
  assign bus.cnt_tens  = cnt0[7:4];
  assign bus.cnt_ones  = cnt0[3:0];
  assign bus1.cnt_tens = cnt1[7:4];
  assign bus1.cnt_ones = cnt1[3:0];

  typedef struct {
    int         id;
    int         cyc;
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       er;
  } ev_t;

  ev_t sb[$];
  int  nTests = 0;
  int  nFail  = 0;
  int  cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEv(input int id, input int c, input logic [1:0] st,
                        input logic en, input logic clr, input logic er);
    ev_t e;
    e.id = id; e.cyc = c; e.st = st; e.en = en; e.clr = clr; e.er = er;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: an event is any enable/clear pulse or a change of state or err
  logic [1:0] prevSt  = 2'b00;
  logic       prevErr = 1'b0;
  always @(negedge clk) begin
    ev_t  e;
    logic evt;
    logic expBusy, expDone;
    evt = bus.cnt_en || bus.cnt_clr || (bus.state !== prevSt) || (bus.err !== prevErr);
    prevSt  = bus.state;
    prevErr = bus.err;
    if (evt) begin
      nTests++;
      if (sb.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_event: got cyc=%0d st=%0d en=%0b clr=%0b err=%0b, want no event",
                 cyc, bus.state, bus.cnt_en, bus.cnt_clr, bus.err);
      end else begin
        e = sb.pop_front();
        expBusy = (e.st == S_RUN) || (e.st == S_PAUSE);
        expDone = (e.st == S_DONE);
        if (e.cyc != cyc || bus.state !== e.st || bus.cnt_en !== e.en || bus.cnt_clr !== e.clr ||
            bus.err !== e.er || bus.busy !== expBusy || bus.done !== expDone) begin
          nFail++;
          $display("FAIL event_t%0d: got cyc=%0d st=%0d en=%0b clr=%0b err=%0b busy=%0b done=%0b, want cyc=%0d st=%0d en=%0b clr=%0b err=%0b",
                   e.id, cyc, bus.state, bus.cnt_en, bus.cnt_clr, bus.err, bus.busy, bus.done,
                   e.cyc, e.st, e.en, e.clr, e.er);
        end
      end
    end
  end

  task automatic clearFromDone(input int id);
    int c;
    tick();
    bus.clear = 1'b1;
    c = cyc;
    pushEv(id, c,     S_DONE, 1'b0, 1'b1, 1'b0);
    pushEv(id, c + 1, S_IDLE, 1'b0, 1'b0, 1'b0);
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    int s;
    int enCnt;
    int doneAt;

    reset = 1'b0;
    bus.start = 1'b0;  bus.stop = 1'b0;  bus.clear = 1'b0;
    bus.target_tens = 4'd0;  bus.target_ones = 4'd0;
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.clear = 1'b0;
    bus1.target_tens = 4'd0; bus1.target_ones = 4'd0;

    tick(); tick();
    check("rst_state",  32'(bus.state),   32'd0);
    check("rst_busy",   32'(bus.busy),    32'd0);
    check("rst_done",   32'(bus.done),    32'd0);
    check("rst_err",    32'(bus.err),     32'd0);
    check("rst_cnt_en", 32'(bus.cnt_en),  32'd0);
    check("rst_cnt_clr",32'(bus.cnt_clr), 32'd0);
    reset = 1'b1;
    tick(); tick();

    // 1: asynchronous reset during RUN cycle 6, target 05
    bus.target_tens = 4'd0; bus.target_ones = 4'd5;
    tick();
    bus.start = 1'b1;
    s = cyc;
    pushEv(1, s,     S_IDLE, 1'b0, 1'b1, 1'b0);
    pushEv(1, s + 1, S_RUN,  1'b0, 1'b0, 1'b0);
    pushEv(1, s + 4, S_RUN,  1'b1, 1'b0, 1'b0);
    pushEv(1, s + 6, S_IDLE, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    #1 reset = 1'b0;
    #1;
    check("async_rst_state",  32'(bus.state),  32'd0);
    check("async_rst_busy",   32'(bus.busy),   32'd0);
    check("async_rst_done",   32'(bus.done),   32'd0);
    check("async_rst_cnt_en", 32'(bus.cnt_en), 32'd0);
    tick(); tick();
    reset = 1'b1;
    repeat (6) tick();

    // 2: target 03, enables at RUN cycles 4/8/12, DONE at 14
    bus.target_tens = 4'd0; bus.target_ones = 4'd3;
    tick();
    bus.start = 1'b1;
    s = cyc;
    pushEv(2, s,      S_IDLE, 1'b0, 1'b1, 1'b0);
    pushEv(2, s + 1,  S_RUN,  1'b0, 1'b0, 1'b0);
    pushEv(2, s + 4,  S_RUN,  1'b1, 1'b0, 1'b0);
    pushEv(2, s + 8,  S_RUN,  1'b1, 1'b0, 1'b0);
    pushEv(2, s + 12, S_RUN,  1'b1, 1'b0, 1'b0);
    pushEv(2, s + 14, S_DONE, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (20) tick();

    // 3: target 00 twice from DONE, no enables
    bus.target_tens = 4'd0; bus.target_ones = 4'd0;
    for (int rep = 0; rep < 2; rep++) begin
      tick();
      bus.start = 1'b1;
      s = cyc;
      pushEv(3, s,     S_DONE, 1'b0, 1'b1, 1'b0);
      pushEv(3, s + 1, S_RUN,  1'b0, 1'b0, 1'b0);
      pushEv(3, s + 2, S_DONE, 1'b0, 1'b0, 1'b0);
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
    end

    // 4: invalid target 1A rejected from IDLE, then valid 12 runs to completion
    clearFromDone(4);
    bus.target_tens = 4'd1; bus.target_ones = 4'hA;
    tick();
    bus.start = 1'b1;
    s = cyc;
    pushEv(4, s + 1, S_IDLE, 1'b0, 1'b0, 1'b1);
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.target_tens = 4'd1; bus.target_ones = 4'd2;
    tick();
    bus.start = 1'b1;
    s = cyc;
    pushEv(4, s,     S_IDLE, 1'b0, 1'b1, 1'b1);
    pushEv(4, s + 1, S_RUN,  1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) pushEv(4, s + 4 * k, S_RUN, 1'b1, 1'b0, 1'b0);
    pushEv(4, s + 50, S_DONE, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (55) tick();

    // 5: target 02, stop at RUN cycle 6, resume keeps partial interval
    clearFromDone(5);
    bus.target_tens = 4'd0; bus.target_ones = 4'd2;
    tick();
    bus.start = 1'b1;
    s = cyc;
    pushEv(5, s,     S_IDLE, 1'b0, 1'b1, 1'b0);
    pushEv(5, s + 1, S_RUN,  1'b0, 1'b0, 1'b0);
    pushEv(5, s + 4, S_RUN,  1'b1, 1'b0, 1'b0);
    pushEv(5, s + 7, S_PAUSE,1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    repeat (9) tick();
    bus.start = 1'b1;
    pushEv(5, s + 17, S_RUN,  1'b0, 1'b0, 1'b0);
    pushEv(5, s + 19, S_RUN,  1'b1, 1'b0, 1'b0);
    pushEv(5, s + 21, S_DONE, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (8) tick();

    // 6: start+stop+clear together in RUN, clear wins
    clearFromDone(6);
    bus.target_tens = 4'd0; bus.target_ones = 4'd5;
    tick();
    bus.start = 1'b1;
    s = cyc;
    pushEv(6, s,     S_IDLE, 1'b0, 1'b1, 1'b0);
    pushEv(6, s + 1, S_RUN,  1'b0, 1'b0, 1'b0);
    pushEv(6, s + 4, S_RUN,  1'b1, 1'b0, 1'b0);
    pushEv(6, s + 6, S_RUN,  1'b0, 1'b1, 1'b0);
    pushEv(6, s + 7, S_IDLE, 1'b0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    bus.start = 1'b1; bus.stop = 1'b1; bus.clear = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    repeat (5) tick();

    // 7: PRESCALE=1 instance, target 03: enable every RUN cycle until match
    bus1.target_tens = 4'd0; bus1.target_ones = 4'd3;
    tick();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    enCnt  = 0;
    doneAt = -1;
    for (int i = 1; i <= 20 && doneAt < 0; i++) begin
      #3;
      if (bus1.done) doneAt = i;
      else if (bus1.cnt_en) enCnt++;
      tick();
    end
    check("p1_en_pulses", 32'(enCnt),      32'd3);
    check("p1_done_cycle",32'(doneAt),     32'd5);
    check("p1_state",     32'(bus1.state), 32'(S_DONE));
    check("p1_busy",      32'(bus1.busy),  32'd0);
    check("p1_err",       32'(bus1.err),   32'd0);

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
